stream_mux_4_to_1_rr: RTL

- Merges four independent valid/ready input streams onto one registered output stream.
- Arbitration is round-robin, with optional packet locking.
- Each output beat carries the 2-bit source index on o_Sel1/o_Sel0, so a downstream 1-to-4 demux can route traffic back per channel.
- Sits between four producer blocks and a shared channel (UART TX path, shared bus).

---
 rtl/stream_mux_4_to_1_rr.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/stream_mux_4_to_1_rr.sv
// stream_mux_4_to_1_rr
//   Merges four valid/ready input streams onto one registered output stream
//   using round-robin arbitration, with optional packet locking.
//
// Ports
//   i_Clk, i_Rst_L               clock, async active-low reset
//   i_Data0..3 / i_Valid0..3     input channel beats
//   i_Last0..3                   end-of-packet marker (PACKET_MODE=1 only)
//   o_Ready0..3                  beat accepted on channel N this cycle
//   o_Data / o_Valid / o_Last    registered output beat
//   o_Sel1, o_Sel0               source channel of the output beat
//   i_Ready                      downstream accepts the output beat
//
// Lock FSM
//   state    | meaning
//   UNLOCKED | grant chosen by round-robin search from prev_q+1
//   LOCKED   | grant pinned to prev_q until a Last=1 beat transfers
module stream_mux_4_to_1_rr #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACKET_MODE = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [DATA_WIDTH-1:0] i_Data0,
    input  logic [DATA_WIDTH-1:0] i_Data1,
    input  logic [DATA_WIDTH-1:0] i_Data2,
    input  logic [DATA_WIDTH-1:0] i_Data3,
    input  logic                  i_Valid0,
    input  logic                  i_Valid1,
    input  logic                  i_Valid2,
    input  logic                  i_Valid3,
    input  logic                  i_Last0,
    input  logic                  i_Last1,
    input  logic                  i_Last2,
    input  logic                  i_Last3,
    output logic                  o_Ready0,
    output logic                  o_Ready1,
    output logic                  o_Ready2,
    output logic                  o_Ready3,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    output logic                  o_Last,
    output logic                  o_Sel1,
    output logic                  o_Sel0,
    input  logic                  i_Ready
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [1:0]            sel_q, sel_d;
    logic [1:0]            prev_q, prev_d;
    logic [0:0]            lock_state_q, lock_state_d;

    logic [3:0]            valid_in;
    logic [3:0]            last_in;
    logic                  load;
    logic [1:0]            grant;
    logic                  grant_valid;
    logic                  grant_last;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [1:0]            idx;

    assign valid_in = {i_Valid3, i_Valid2, i_Valid1, i_Valid0};
    assign last_in  = {i_Last3, i_Last2, i_Last1, i_Last0};

    // Refill whenever the output register is empty or being drained.
    assign load = !valid_q | i_Ready;

    always_comb begin
        grant       = 2'd0;
        grant_valid = 1'b0;
        idx         = 2'd0;
        if (lock_state_q == LOCKED) begin
            grant       = prev_q;
            grant_valid = valid_in[prev_q];
        end else begin
            // Walk from farthest (prev_q itself) to nearest (prev_q+1) so the
            // nearest valid channel is the last one written and wins.
            for (int k = 4; k >= 1; k--) begin
                idx = prev_q + k[1:0];
                if (valid_in[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = i_Data0;
        case (grant)
            2'd0: grant_data = i_Data0;
            2'd1: grant_data = i_Data1;
            2'd2: grant_data = i_Data2;
            default: grant_data = i_Data3;
        endcase
        grant_last = (PACKET_MODE != 0) ? last_in[grant] : 1'b1;
    end

    assign o_Ready0 = load & grant_valid & (grant == 2'd0);
    assign o_Ready1 = load & grant_valid & (grant == 2'd1);
    assign o_Ready2 = load & grant_valid & (grant == 2'd2);
    assign o_Ready3 = load & grant_valid & (grant == 2'd3);

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        sel_d        = sel_q;
        prev_d       = prev_q;
        lock_state_d = lock_state_q;
        if (load) begin
            valid_d = grant_valid;
            if (grant_valid) begin
                data_d = grant_data;
                last_d = grant_last;
                sel_d  = grant;
                prev_d = grant;
                // grant_last is forced 1 in beat mode, so the lock never engages.
                lock_state_d = grant_last ? UNLOCKED : LOCKED;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            sel_q        <= 2'd0;
            prev_q       <= 2'd3;
            lock_state_q <= UNLOCKED;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            prev_q       <= prev_d;
            lock_state_q <= lock_state_d;
        end
    end

    assign o_Data  = data_q;
    assign o_Valid = valid_q;
    assign o_Last  = last_q;
    assign o_Sel1  = sel_q[1];
    assign o_Sel0  = sel_q[0];

endmodule
